// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcode encodings, immediate formats and
// default datapath widths for the decode stage.
package rv_pkg;

  localparam int REG_SIZE_DEF      = 32;
  localparam int REG_FILE_BITS_DEF = 5;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Immediate format selected by the decoder; NONE yields zero (R-type, illegal).
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: reassembles the scattered RV32I immediate bits for the
// selected format and sign-extends to the datapath width. Opcode bits are not
// needed here, so only instr[31:7] is taken.
module imm_gen
  import rv_pkg::*;
#(
  parameter int REG_SIZE = REG_SIZE_DEF
) (
  input  logic [31:7]         instr,
  input  imm_type_e           imm_type,
  output logic [REG_SIZE-1:0] imm
);

  logic [31:0] imm32;

  // Per-format bit reassembly into a 32-bit signed immediate
  always_comb begin
    imm32 = '0;
    case (imm_type)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = REG_SIZE'($signed(imm32));

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decodes the IF/ID instruction, reads operands from the
// register file, detects load-use hazards against the ID/EX slot and owns the
// ID/EX pipeline register (flush > hold > bubble > capture).
module id_stage
  import rv_pkg::*;
#(
  parameter int REG_FILE_BITS = REG_FILE_BITS_DEF,
  parameter int REG_SIZE      = REG_SIZE_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_valid,
  input  logic [31:0]              if_instr,
  input  logic [REG_SIZE-1:0]      if_pc,
  input  logic                     flush,
  input  logic                     ex_hold,
  output logic [REG_FILE_BITS-1:0] rf_read_num1,
  output logic [REG_FILE_BITS-1:0] rf_read_num2,
  input  logic [REG_SIZE-1:0]      rf_out_reg1,
  input  logic [REG_SIZE-1:0]      rf_out_reg2,
  output logic                     id_stall,
  output logic                     ex_valid,
  output logic [REG_SIZE-1:0]      ex_pc,
  output logic [REG_SIZE-1:0]      ex_rs1_val,
  output logic [REG_SIZE-1:0]      ex_rs2_val,
  output logic [REG_SIZE-1:0]      ex_imm,
  output logic [REG_FILE_BITS-1:0] ex_rd,
  output logic [REG_FILE_BITS-1:0] ex_rs1_num,
  output logic [REG_FILE_BITS-1:0] ex_rs2_num,
  output logic [6:0]               ex_opcode,
  output logic [2:0]               ex_funct3,
  output logic                     ex_funct7b5,
  output logic                     ex_reg_we,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic                     ex_illegal
);

  typedef struct packed {
    logic                     valid;
    logic [REG_SIZE-1:0]      pc;
    logic [REG_SIZE-1:0]      rs1_val;
    logic [REG_SIZE-1:0]      rs2_val;
    logic [REG_SIZE-1:0]      imm;
    logic [REG_FILE_BITS-1:0] rd;
    logic [REG_FILE_BITS-1:0] rs1_num;
    logic [REG_FILE_BITS-1:0] rs2_num;
    logic [6:0]               opcode;
    logic [2:0]               funct3;
    logic                     funct7b5;
    logic                     reg_we;
    logic                     mem_read;
    logic                     mem_write;
    logic                     illegal;
  } idex_t;

  idex_t ex_d, ex_q;
  idex_t cap;

  logic [6:0]               opcode;
  logic [REG_FILE_BITS-1:0] rd, rs1, rs2;
  logic                     dec_legal, dec_rs1_used, dec_rs2_used;
  logic                     dec_we, dec_mr, dec_mw;
  imm_type_e                dec_imm_type;
  logic [REG_SIZE-1:0]      dec_imm;
  logic                     load_use;

  assign opcode = if_instr[6:0];
  assign rd     = REG_FILE_BITS'(if_instr[11:7]);
  assign rs1    = REG_FILE_BITS'(if_instr[19:15]);
  assign rs2    = REG_FILE_BITS'(if_instr[24:20]);

  // Register file indices come straight from the instruction, valid or not
  assign rf_read_num1 = rs1;
  assign rf_read_num2 = rs2;

  // Opcode decode: operand usage, control bits and immediate format
  always_comb begin
    dec_legal    = 1'b1;
    dec_rs1_used = 1'b1;
    dec_rs2_used = 1'b0;
    dec_we       = 1'b0;
    dec_mr       = 1'b0;
    dec_mw       = 1'b0;
    dec_imm_type = IMM_NONE;
    case (opcode)
      OPC_LOAD: begin
        dec_we       = 1'b1;
        dec_mr       = 1'b1;
        dec_imm_type = IMM_I;
      end
      OPC_STORE: begin
        dec_rs2_used = 1'b1;
        dec_mw       = 1'b1;
        dec_imm_type = IMM_S;
      end
      OPC_BRANCH: begin
        dec_rs2_used = 1'b1;
        dec_imm_type = IMM_B;
      end
      OPC_JAL: begin
        dec_rs1_used = 1'b0;
        dec_we       = 1'b1;
        dec_imm_type = IMM_J;
      end
      OPC_JALR: begin
        dec_we       = 1'b1;
        dec_imm_type = IMM_I;
      end
      OPC_OP: begin
        dec_rs2_used = 1'b1;
        dec_we       = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_we       = 1'b1;
        dec_imm_type = IMM_I;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_rs1_used = 1'b0;
        dec_we       = 1'b1;
        dec_imm_type = IMM_U;
      end
      default: dec_legal = 1'b0;
    endcase
    // Writes to x0 are architecturally dropped; suppress them here so EX
    // forwarding never sees a phantom producer of x0.
    if (rd == '0) dec_we = 1'b0;
  end

  imm_gen #(.REG_SIZE(REG_SIZE)) u_imm_gen (
    .instr    (if_instr[31:7]),
    .imm_type (dec_imm_type),
    .imm      (dec_imm)
  );

  // A load in EX cannot forward in time to a dependent instruction in ID
  assign load_use = if_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
                    ((dec_rs1_used & (ex_q.rd == rs1)) |
                     (dec_rs2_used & (ex_q.rd == rs2)));

  // Flush redirects IF, so the stall is released even if other stall causes exist
  assign id_stall = ~rst & ~flush & (ex_hold | load_use);

  // Decoded instruction as it would be captured into ID/EX
  always_comb begin
    cap           = '0;
    cap.valid     = if_valid;
    cap.pc        = if_pc;
    cap.rs1_val   = rf_out_reg1;
    cap.rs2_val   = rf_out_reg2;
    cap.imm       = dec_imm;
    cap.rd        = rd;
    cap.rs1_num   = rs1;
    cap.rs2_num   = rs2;
    cap.opcode    = opcode;
    cap.funct3    = if_instr[14:12];
    cap.funct7b5  = if_instr[30];
    cap.reg_we    = if_valid & dec_we;
    cap.mem_read  = if_valid & dec_mr;
    cap.mem_write = if_valid & dec_mw;
    cap.illegal   = if_valid & ~dec_legal;
  end

  // ID/EX next-state selection in priority order: flush, hold, bubble, capture
  always_comb begin
    ex_d = ex_q;
    if (flush || (!ex_hold && load_use)) begin
      ex_d.valid     = 1'b0;
      ex_d.reg_we    = 1'b0;
      ex_d.mem_read  = 1'b0;
      ex_d.mem_write = 1'b0;
      ex_d.illegal   = 1'b0;
    end else if (ex_hold) begin
      ex_d = ex_q;
    end else begin
      ex_d = cap;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_rs1_val   = ex_q.rs1_val;
  assign ex_rs2_val   = ex_q.rs2_val;
  assign ex_imm       = ex_q.imm;
  assign ex_rd        = ex_q.rd;
  assign ex_rs1_num   = ex_q.rs1_num;
  assign ex_rs2_num   = ex_q.rs2_num;
  assign ex_opcode    = ex_q.opcode;
  assign ex_funct3    = ex_q.funct3;
  assign ex_funct7b5  = ex_q.funct7b5;
  assign ex_reg_we    = ex_q.reg_we;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios followed by random
// instruction streams with random flush/hold/reset, checked against a
// behavioural model of the decode stage.
module tb_id_stage;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic        ex_hold;
  logic [4:0]  rf_read_num1, rf_read_num2;
  logic [31:0] rf_out_reg1, rf_out_reg2;
  logic        id_stall;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rd, ex_rs1_num, ex_rs2_num;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5, ex_reg_we, ex_mem_read, ex_mem_write, ex_illegal;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] regs [32];
  logic        last_stall;

  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1v, rs2v, imm;
    logic [4:0]  rd, rs1n, rs2n;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7b5, we, mr, mw, ill;
    logic        ctrl_k, data_k;
  } exp_t;

  exp_t m;

  id_stage #(.REG_FILE_BITS(5), .REG_SIZE(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .flush        (flush),
    .ex_hold      (ex_hold),
    .rf_read_num1 (rf_read_num1),
    .rf_read_num2 (rf_read_num2),
    .rf_out_reg1  (rf_out_reg1),
    .rf_out_reg2  (rf_out_reg2),
    .id_stall     (id_stall),
    .ex_valid     (ex_valid),
    .ex_pc        (ex_pc),
    .ex_rs1_val   (ex_rs1_val),
    .ex_rs2_val   (ex_rs2_val),
    .ex_imm       (ex_imm),
    .ex_rd        (ex_rd),
    .ex_rs1_num   (ex_rs1_num),
    .ex_rs2_num   (ex_rs2_num),
    .ex_opcode    (ex_opcode),
    .ex_funct3    (ex_funct3),
    .ex_funct7b5  (ex_funct7b5),
    .ex_reg_we    (ex_reg_we),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_illegal   (ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file stand-in: combinational read, x0 kept at zero
  assign rf_out_reg1 = regs[rf_read_num1];
  assign rf_out_reg2 = regs[rf_read_num2];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sx(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  function automatic logic [31:0] model_imm(input logic [31:0] ins);
    logic [6:0] op;
    int         v;
    op = ins[6:0];
    v  = 0;
    if (op == 7'h03 || op == 7'h13 || op == 7'h67)
      v = sx(int'(ins[31:20]), 12);
    else if (op == 7'h23)
      v = sx(int'(ins[31:25]) * 32 + int'(ins[11:7]), 12);
    else if (op == 7'h63)
      v = sx(int'(ins[31]) * 4096 + int'(ins[7]) * 2048 +
             int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2, 13);
    else if (op == 7'h37 || op == 7'h17)
      return ins & 32'hFFFF_F000;
    else if (op == 7'h6F)
      v = sx(int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * 4096 +
             int'(ins[20]) * 2048 + int'(ins[30:21]) * 2, 21);
    return 32'(v);
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op inside {7'h37, 7'h17, 7'h6F});
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {7'h33, 7'h23, 7'h63};
  endfunction

  function automatic exp_t model_capture(input logic [31:0] ins, input logic [31:0] pc,
                                         input logic v);
    exp_t       e;
    logic [6:0] op;
    logic       legal, writes;
    op     = ins[6:0];
    legal  = op inside {7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h33, 7'h13, 7'h37, 7'h17};
    writes = (op inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67}) && (ins[11:7] != 5'd0);
    e.valid  = v;
    e.pc     = pc;
    e.rs1v   = regs[ins[19:15]];
    e.rs2v   = regs[ins[24:20]];
    e.imm    = model_imm(ins);
    e.rd     = ins[11:7];
    e.rs1n   = ins[19:15];
    e.rs2n   = ins[24:20];
    e.opc    = op;
    e.f3     = ins[14:12];
    e.f7b5   = ins[30];
    e.we     = v && writes;
    e.mr     = v && (op == 7'h03);
    e.mw     = v && (op == 7'h23);
    e.ill    = v && !legal;
    e.ctrl_k = 1'b1;
    e.data_k = v;
    return e;
  endfunction

  task automatic check_ex();
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
    if (m.ctrl_k) begin
      chk("ex_reg_we",    {31'd0, ex_reg_we},    {31'd0, m.we});
      chk("ex_mem_read",  {31'd0, ex_mem_read},  {31'd0, m.mr});
      chk("ex_mem_write", {31'd0, ex_mem_write}, {31'd0, m.mw});
      chk("ex_illegal",   {31'd0, ex_illegal},   {31'd0, m.ill});
    end
    if (m.data_k) begin
      chk("ex_pc",       ex_pc,      m.pc);
      chk("ex_rs1_val",  ex_rs1_val, m.rs1v);
      chk("ex_rs2_val",  ex_rs2_val, m.rs2v);
      chk("ex_imm",      ex_imm,     m.imm);
      chk("ex_rd",       {27'd0, ex_rd},      {27'd0, m.rd});
      chk("ex_rs1_num",  {27'd0, ex_rs1_num}, {27'd0, m.rs1n});
      chk("ex_rs2_num",  {27'd0, ex_rs2_num}, {27'd0, m.rs2n});
      chk("ex_opcode",   {25'd0, ex_opcode},  {25'd0, m.opc});
      chk("ex_funct3",   {29'd0, ex_funct3},  {29'd0, m.f3});
      chk("ex_funct7b5", {31'd0, ex_funct7b5}, {31'd0, m.f7b5});
    end
  endtask

  // One clock: check combinational outputs mid-cycle, advance model at the edge,
  // then check registered outputs just after the edge.
  task automatic cycle();
    exp_t       nxt;
    logic [6:0] op;
    logic       haz, exp_stall;
    @(negedge clk);
    op  = if_instr[6:0];
    haz = if_valid && m.valid && m.mr && (m.rd != 5'd0) &&
          ((uses_rs1(op) && m.rd == if_instr[19:15]) ||
           (uses_rs2(op) && m.rd == if_instr[24:20]));
    exp_stall = !rst && !flush && (ex_hold || haz);
    chk("id_stall",     {31'd0, id_stall},     {31'd0, exp_stall});
    chk("rf_read_num1", {27'd0, rf_read_num1}, {27'd0, if_instr[19:15]});
    chk("rf_read_num2", {27'd0, rf_read_num2}, {27'd0, if_instr[24:20]});
    last_stall = id_stall;
    nxt = m;
    if (rst) begin
      nxt = '{default: '0};
      nxt.ctrl_k = 1'b1;
      nxt.data_k = 1'b1;
    end else if (flush) begin
      nxt.valid  = 1'b0;
      nxt.ctrl_k = 1'b0;
      nxt.data_k = 1'b0;
    end else if (ex_hold) begin
      nxt = m;
    end else if (haz) begin
      nxt.valid  = 1'b0;
      nxt.we     = 1'b0;
      nxt.mr     = 1'b0;
      nxt.mw     = 1'b0;
      nxt.ill    = 1'b0;
      nxt.ctrl_k = 1'b1;
      nxt.data_k = 1'b0;
    end else begin
      nxt = model_capture(if_instr, if_pc, if_valid);
    end
    @(posedge clk);
    #1;
    m = nxt;
    check_ex();
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    if_valid = v;
    if_instr = ins;
    if_pc    = pc;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int          k;
    w        = $urandom;
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    k = $urandom_range(0, 11);
    case (k)
      0, 10, 11: w[6:0] = 7'h03;
      1:         w[6:0] = 7'h23;
      2:         w[6:0] = 7'h63;
      3:         w[6:0] = 7'h6F;
      4:         w[6:0] = 7'h67;
      5:         w[6:0] = 7'h33;
      6:         w[6:0] = 7'h13;
      7:         w[6:0] = 7'h37;
      8:         w[6:0] = 7'h17;
      default:   w[6:0] = 7'h7F;
    endcase
    return w;
  endfunction

  initial begin
    m = '{default: '0};
    last_stall = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;
    rst = 1'b1; flush = 1'b0; ex_hold = 1'b0;
    drive(1'b0, 32'h0000_0013, 32'd0);

    // Reset state
    cycle();
    cycle();
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_ex_pc", ex_pc, 32'd0);
    chk("rst_stall", {31'd0, last_stall}, 32'd0);
    rst = 1'b0;

    // ADDI x5,x0,-1 at 0x100
    drive(1'b1, 32'hFFF0_0293, 32'h100);
    cycle();
    chk("addi_valid", {31'd0, ex_valid}, 32'd1);
    chk("addi_imm", ex_imm, 32'hFFFF_FFFF);
    chk("addi_rd", {27'd0, ex_rd}, 32'd5);
    chk("addi_we", {31'd0, ex_reg_we}, 32'd1);
    chk("addi_pc", ex_pc, 32'h100);

    // LW x6,0(x1) then dependent ADD x7,x6,x2: one bubble
    drive(1'b1, 32'h0000_A303, 32'h104);
    cycle();
    drive(1'b1, 32'h0023_03B3, 32'h108);
    cycle();
    chk("lu_stall", {31'd0, last_stall}, 32'd1);
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    cycle();
    chk("lu_stall_release", {31'd0, last_stall}, 32'd0);
    chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_add_rs1", ex_rs1_val, regs[6]);

    // LW x0 does not create a hazard; ADD to x0 does not write
    drive(1'b1, 32'h0000_A003, 32'h10C);
    cycle();
    drive(1'b1, 32'h0020_03B3, 32'h110);
    cycle();
    chk("x0_no_stall", {31'd0, last_stall}, 32'd0);
    drive(1'b1, 32'h0020_8033, 32'h114);
    cycle();
    chk("x0_rd_we", {31'd0, ex_reg_we}, 32'd0);

    // flush beats hold and load-use
    drive(1'b1, 32'h0000_A303, 32'h118);
    cycle();
    drive(1'b1, 32'h0023_03B3, 32'h11C);
    flush = 1'b1; ex_hold = 1'b1;
    cycle();
    chk("flush_stall", {31'd0, last_stall}, 32'd0);
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    flush = 1'b0; ex_hold = 1'b0;

    // BEQ x1,x2,-8 held for three cycles
    drive(1'b1, 32'hFE20_8CE3, 32'h200);
    cycle();
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rand_instr(), 32'h204 + 32'(i * 4));
      cycle();
      chk("hold_imm", ex_imm, 32'hFFFF_FFF8);
      chk("hold_pc", ex_pc, 32'h200);
      chk("hold_stall", {31'd0, last_stall}, 32'd1);
    end
    ex_hold = 1'b0;

    // Reset while a load-use stall is pending
    drive(1'b1, 32'h0000_A303, 32'h300);
    cycle();
    drive(1'b1, 32'h0023_03B3, 32'h304);
    rst = 1'b1;
    cycle();
    chk("rstlu_stall", {31'd0, last_stall}, 32'd0);
    chk("rstlu_valid", {31'd0, ex_valid}, 32'd0);
    chk("rstlu_rd", {27'd0, ex_rd}, 32'd0);
    chk("rstlu_imm", ex_imm, 32'd0);
    chk("rstlu_mr", {31'd0, ex_mem_read}, 32'd0);
    rst = 1'b0;

    // Unknown opcode passes as illegal without side effects
    drive(1'b1, 32'h0000_01FF, 32'h308);
    cycle();
    chk("ill_valid", {31'd0, ex_valid}, 32'd1);
    chk("ill_flag", {31'd0, ex_illegal}, 32'd1);
    chk("ill_we", {31'd0, ex_reg_we}, 32'd0);

    // Random traffic; IF keeps its slot while stalled
    for (int n = 0; n < 800; n++) begin
      rst     = ($urandom_range(0, 49) == 0);
      flush   = ($urandom_range(0, 9) == 0);
      ex_hold = ($urandom_range(0, 6) == 0);
      if (!last_stall || rst)
        drive(($urandom_range(0, 9) != 0), rand_instr(), if_pc + 32'd4);
      if ($urandom_range(0, 3) == 0) regs[$urandom_range(1, 31)] = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
